// File: rtl/crc16_checker.sv
// crc16_checker: receive-side USB CRC16 checker.
// Consumes a de-stuffed serial stream (payload followed by the 16 received CRC
// bits, LSB of each byte first) and reports whether the final LFSR remainder
// equals the USB CRC16 residual, together with a packet length check.
//
// Handshake: there is no back-pressure. s_in is a bit only in cycles where
// s_in_valid is high; chk_end is meaningful only together with s_in_valid.
// chk_start is a one-cycle pulse accepted in any state and wins over a bit
// presented in the same cycle (that bit is dropped).
module crc16_checker #(
  parameter int unsigned MAX_BITS = 8208,
  parameter int unsigned MIN_BITS = 16,
  parameter logic [15:0] INIT     = 16'hFFFF,
  parameter logic [15:0] RESIDUE  = 16'h800D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        chk_start,
  input  logic        s_in,
  input  logic        s_in_valid,
  input  logic        chk_end,
  output logic        chk_busy,
  output logic        chk_done,
  output logic        crc_ok,
  output logic        len_err,
  output logic [15:0] crc16_val,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [13:0] CNT_LAST = 14'(MAX_BITS - 1);
  localparam logic [13:0] CNT_MIN  = 14'(MIN_BITS);
  localparam logic [13:0] CNT_SAT  = 14'h3FFF;
  localparam logic [15:0] POLY     = 16'h8005;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_lfsr;
  logic [13:0] r_bit_cnt;
  logic        r_crc_ok;
  logic        r_len_err;

  logic        w_fb;
  logic [15:0] w_lfsr_step;
  logic [13:0] w_cnt_inc;
  logic        w_consume;
  logic        w_last_bit;
  logic        w_len_bad;

  // One LFSR step for the bit on s_in; the counter saturates instead of wrapping.
  always_comb begin
    w_fb        = s_in ^ r_lfsr[15];
    w_lfsr_step = {r_lfsr[14:0], 1'b0} ^ (w_fb ? POLY : 16'h0000);
    w_cnt_inc   = (r_bit_cnt == CNT_SAT) ? r_bit_cnt : r_bit_cnt + 14'd1;
    // A bit is consumed only in RUN, and never in a (re)start cycle.
    w_consume   = (r_state == ST_RUN) && s_in_valid && !chk_start;
    // Packet ends on the flagged bit, or is aborted on bit MAX_BITS without it.
    w_last_bit  = w_consume && (chk_end || (r_bit_cnt == CNT_LAST));
    // Evaluated only on the last bit: abort, or too few bits in total.
    w_len_bad   = !chk_end || (w_cnt_inc < CNT_MIN);
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (chk_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (chk_start)       w_state_next = ST_RUN;
        else if (w_last_bit) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = chk_start ? ST_RUN : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath: preset on start, shift on consumed bits, register the verdict on
  // the last bit so it is already valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= INIT;
      r_bit_cnt <= 14'd0;
      r_crc_ok  <= 1'b0;
      r_len_err <= 1'b0;
    end else if (chk_start) begin
      r_lfsr    <= INIT;
      r_bit_cnt <= 14'd0;
      r_crc_ok  <= 1'b0;
      r_len_err <= 1'b0;
    end else if (w_consume) begin
      r_lfsr    <= w_lfsr_step;
      r_bit_cnt <= w_cnt_inc;
      if (w_last_bit) begin
        r_crc_ok  <= (w_lfsr_step == RESIDUE) && !w_len_bad;
        r_len_err <= w_len_bad;
      end
    end
  end

  // Output decode.
  always_comb begin
    chk_busy  = (r_state == ST_RUN);
    chk_done  = (r_state == ST_DONE);
    crc_ok    = r_crc_ok;
    len_err   = r_len_err;
    crc16_val = r_lfsr;
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_crc16_checker.sv
// Bench for crc16_checker: directed sequence with random payloads, checked
// against a reflected (LSB-first) CRC-16/USB reference model.
module tb_crc16_checker;

  localparam int MAXB = 8208;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chk_start = 1'b0;
  logic        s_in = 1'b0;
  logic        s_in_valid = 1'b0;
  logic        chk_end = 1'b0;
  logic        chk_busy;
  logic        chk_done;
  logic        crc_ok;
  logic        len_err;
  logic [15:0] crc16_val;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [15:0] m_r;
  logic        pkt_q[$];

  crc16_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chk_start  (chk_start),
    .s_in       (s_in),
    .s_in_valid (s_in_valid),
    .chk_end    (chk_end),
    .chk_busy   (chk_busy),
    .chk_done   (chk_done),
    .crc_ok     (crc_ok),
    .len_err    (len_err),
    .crc16_val  (crc16_val),
    .dbg_state  (dbg_state)
  );

  // clock / pulse counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (chk_done === 1'b1) done_cnt++;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = v[15-k];
    return r;
  endfunction

  // Reflected CRC-16/USB, one wire bit at a time.
  function automatic logic [15:0] ref_bit(input logic [15:0] r, input logic b);
    logic [15:0] sh;
    sh = r >> 1;
    return ((b ^ r[0]) != 1'b0) ? (sh ^ 16'hA001) : sh;
  endfunction

  // Golden transmit side: random payload, CRC-16/USB appended LSB first.
  task automatic build_good(input int nbytes);
    logic [15:0] crc;
    logic [7:0]  b;
    pkt_q.delete();
    crc = 16'hFFFF;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++) pkt_q.push_back(b[k]);
      crc = crc ^ {8'h00, b};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    end
    crc = ~crc;
    for (int k = 0; k < 16; k++) pkt_q.push_back(crc[k]);
  endtask

  task automatic start_pkt();
    chk_start = 1'b1;
    s_in = 1'($urandom_range(0, 1));
    s_in_valid = 1'($urandom_range(0, 1));
    tick();
    chk_start = 1'b0;
    s_in_valid = 1'b0;
    m_r = 16'hFFFF;
    check("start_busy", chk_busy, 1);
    check("start_crc", crc16_val, 16'hFFFF);
    check("start_ok", crc_ok, 0);
    check("start_len", len_err, 0);
  endtask

  task automatic send_bit(input logic b, input logic last, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      s_in_valid = 1'b0;
      s_in = 1'($urandom_range(0, 1));
      chk_end = 1'($urandom_range(0, 1));
      tick();
      check("gap_frozen", crc16_val, bitrev16(m_r));
      check("gap_busy", chk_busy, 1);
    end
    s_in = b;
    s_in_valid = 1'b1;
    chk_end = last;
    tick();
    s_in_valid = 1'b0;
    chk_end = 1'b0;
    m_r = ref_bit(m_r, b);
    check("bit_crc", crc16_val, bitrev16(m_r));
  endtask

  task automatic run_packet(input int gap_max, input bit with_end, input bit tail);
    int          n;
    logic        exp_len;
    logic        exp_ok;
    logic [15:0] exp_v;
    n = pkt_q.size();
    start_pkt();
    for (int i = 0; i < n; i++) begin
      send_bit(pkt_q[i], with_end && (i == n - 1), $urandom_range(0, gap_max));
      if (i < n - 1) check("no_early_done", chk_done, 0);
    end
    exp_len = (n < 16) || !with_end;
    exp_v   = bitrev16(m_r);
    exp_ok  = (exp_v == 16'h800D) && !exp_len;
    check("end_done", chk_done, 1);
    check("end_busy", chk_busy, 0);
    check("end_crc", crc16_val, exp_v);
    check("end_len", len_err, exp_len);
    check("end_ok", crc_ok, exp_ok);
    if (tail) begin
      tick();
      check("done_pulse", chk_done, 0);
      check("held_ok", crc_ok, exp_ok);
      check("held_len", len_err, exp_len);
    end
  endtask

  initial begin
    int d0;
    int idx;

    // reset
    #12;
    check("rst_busy", chk_busy, 0);
    check("rst_done", chk_done, 0);
    check("rst_ok", crc_ok, 0);
    check("rst_len", len_err, 0);
    check("rst_crc", crc16_val, 16'hFFFF);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // inputs in IDLE are ignored
    s_in = 1'b1; s_in_valid = 1'b1; chk_end = 1'b1;
    tick();
    s_in_valid = 1'b0; chk_end = 1'b0;
    check("idle_crc", crc16_val, 16'hFFFF);
    check("idle_done", chk_done, 0);

    // empty payload
    pkt_q.delete();
    for (int i = 0; i < 16; i++) pkt_q.push_back(1'b0);
    run_packet(0, 1, 0);
    check("empty_residue", crc16_val, 16'h800D);
    check("empty_ok", crc_ok, 1);
    tick();

    // random good packets, then the same with one bit flipped
    for (int p = 0; p < 6; p++) begin
      build_good($urandom_range(1, 64));
      run_packet(0, 1, 1);
      check("good_ok", crc_ok, 1);
      idx = $urandom_range(0, pkt_q.size() - 1);
      pkt_q[idx] = ~pkt_q[idx];
      run_packet(0, 1, 1);
      check("flip_ok", crc_ok, 0);
    end

    // gaps between bits
    for (int p = 0; p < 4; p++) begin
      build_good($urandom_range(1, 16));
      run_packet(5, 1, 1);
      check("gap_good_ok", crc_ok, 1);
    end

    // short packet
    pkt_q.delete();
    for (int i = 0; i < 8; i++) pkt_q.push_back(1'($urandom_range(0, 1)));
    run_packet(1, 1, 1);
    check("short_len", len_err, 1);
    check("short_ok", crc_ok, 0);

    // overlong packet: abort on bit MAXB
    pkt_q.delete();
    for (int i = 0; i < MAXB; i++) pkt_q.push_back(1'($urandom_range(0, 1)));
    run_packet(0, 0, 1);
    check("long_len", len_err, 1);
    check("long_ok", crc_ok, 0);

    // restart mid-packet
    start_pkt();
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
    d0 = done_cnt;
    build_good($urandom_range(1, 8));
    run_packet(2, 1, 1);
    check("restart_ok", crc_ok, 1);
    check("restart_one_done", done_cnt - d0, 1);

    // start in the DONE cycle
    build_good(3);
    run_packet(0, 1, 0);
    check("b2b_first_ok", crc_ok, 1);
    build_good(5);
    run_packet(1, 1, 1);
    check("b2b_second_ok", crc_ok, 1);

    // asynchronous reset mid-packet
    start_pkt();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", chk_busy, 0);
    check("arst_done", chk_done, 0);
    check("arst_crc", crc16_val, 16'hFFFF);
    check("arst_ok", crc_ok, 0);
    check("arst_len", len_err, 0);
    rst_n = 1'b1;
    tick();
    build_good($urandom_range(1, 8));
    run_packet(1, 1, 1);
    check("post_rst_ok", crc_ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
